// File: rtl/frequency_analyzer_pkg.sv
// frequency_analyzer_pkg: shared FSM encoding, symbol codes and counter width for the sequencer.
package frequency_analyzer_pkg;
    localparam int CNT_W = 32;
    localparam logic SYMBOL_F0 = 1'b0;
    localparam logic SYMBOL_F1 = 1'b1;
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_MEASURE, S_FLUSH, S_SAMPLE} state_t;
endpackage

// File: rtl/frequency_analyzer_sequencer_if.sv
// frequency_analyzer_sequencer_if: valid/ready result bus from the sequencer to the symbol consumer.
interface frequency_analyzer_sequencer_if;
    import frequency_analyzer_pkg::*;
    logic result_valid;
    logic result_ready;
    logic result_symbol;
    logic result_undetermined;
    logic [CNT_W-1:0] result_f0;
    logic [CNT_W-1:0] result_f1;
    logic [CNT_W-1:0] result_unknown;
    modport master(
        output result_valid, result_symbol, result_undetermined, result_f0, result_f1, result_unknown,
        input result_ready
    );
    modport slave(
        input result_valid, result_symbol, result_undetermined, result_f0, result_f1, result_unknown,
        output result_ready
    );
endinterface

// File: rtl/frequency_symbol_decider.sv
// frequency_symbol_decider: picks the dominant FSK symbol from f0/f1 tick totals.
module frequency_symbol_decider
    import frequency_analyzer_pkg::*;
#(
    parameter logic [CNT_W-1:0] MIN_DOMINANT_TICKS = 1000
) (
    input  logic [CNT_W-1:0] f0,
    input  logic [CNT_W-1:0] f1,
    output logic             symbol,
    output logic             undetermined
);
    logic f0_dom;
    logic f1_dom;
    always_comb begin
        f1_dom = f1 > f0 && f1 >= MIN_DOMINANT_TICKS;
        f0_dom = f0 > f1 && f0 >= MIN_DOMINANT_TICKS;
        symbol = f1_dom ? SYMBOL_F1 : SYMBOL_F0;
        undetermined = !(f0_dom || f1_dom);
    end
endmodule

// File: rtl/frequency_analyzer_sequencer.sv
// frequency_analyzer_sequencer: runs fixed-length analyzer windows and emits one symbol result per window.
// Optional FREQUENCY_ANALYZER_SEQUENCER_STATS_EN adds window_count and dropped_count outputs.
module frequency_analyzer_sequencer
    import frequency_analyzer_pkg::*;
#(
    parameter logic [CNT_W-1:0] DEFAULT_WINDOW_TICKS = 5000,
    parameter logic [CNT_W-1:0] MIN_DOMINANT_TICKS   = 1000
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             run,
    input  logic [CNT_W-1:0] window_ticks,
    input  logic [CNT_W-1:0] an_f0_value,
    input  logic [CNT_W-1:0] an_f1_value,
    input  logic [CNT_W-1:0] an_unknown,
    output logic             an_enable,
    output logic             an_clear,
    frequency_analyzer_sequencer_if.master result,
    output logic             overrun,
    output logic             busy
`ifdef FREQUENCY_ANALYZER_SEQUENCER_STATS_EN
    ,
    output logic [31:0]      window_count,
    output logic [15:0]      dropped_count
`endif
);
    state_t state;
    logic [CNT_W-1:0] count;
    logic symbol;
    logic undetermined;
    logic drop;
    frequency_symbol_decider #(.MIN_DOMINANT_TICKS(MIN_DOMINANT_TICKS)) u_decider (
        .f0(an_f0_value),
        .f1(an_f1_value),
        .symbol(symbol),
        .undetermined(undetermined)
    );
    // A held result that nobody takes this cycle blocks the new one.
    assign drop = result.result_valid && !result.result_ready;
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= S_IDLE;
            count <= '0;
            an_enable <= 1'b0;
            an_clear <= 1'b0;
            busy <= 1'b0;
            overrun <= 1'b0;
            result.result_valid <= 1'b0;
            result.result_symbol <= 1'b0;
            result.result_undetermined <= 1'b0;
            result.result_f0 <= '0;
            result.result_f1 <= '0;
            result.result_unknown <= '0;
`ifdef FREQUENCY_ANALYZER_SEQUENCER_STATS_EN
            window_count <= '0;
            dropped_count <= '0;
`endif
        end else begin
            if (result.result_valid && result.result_ready) result.result_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!run) overrun <= 1'b0;
                    if (run) begin
                        state <= S_CLEAR;
                        busy <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    count <= (window_ticks == '0 ? DEFAULT_WINDOW_TICKS : window_ticks) - CNT_W'(1);
                    state <= S_MEASURE;
                    an_clear <= 1'b1;
                    an_enable <= 1'b1;
                end
                S_MEASURE: begin
                    count <= count - CNT_W'(1);
                    if (!run) begin
                        state <= S_IDLE;
                        an_enable <= 1'b0;
                        an_clear <= 1'b0;
                        busy <= 1'b0;
                    end else if (count == '0) begin
                        state <= S_FLUSH;
                        an_enable <= 1'b0;
                    end
                end
                S_FLUSH: state <= S_SAMPLE;
                S_SAMPLE: begin
                    state <= run ? S_CLEAR : S_IDLE;
                    busy <= run;
                    an_clear <= 1'b0;
                    if (drop) begin
                        overrun <= 1'b1;
`ifdef FREQUENCY_ANALYZER_SEQUENCER_STATS_EN
                        if (dropped_count != 16'hffff) dropped_count <= dropped_count + 16'd1;
`endif
                    end else begin
                        result.result_valid <= 1'b1;
                        result.result_symbol <= symbol;
                        result.result_undetermined <= undetermined;
                        result.result_f0 <= an_f0_value;
                        result.result_f1 <= an_f1_value;
                        result.result_unknown <= an_unknown;
                    end
`ifdef FREQUENCY_ANALYZER_SEQUENCER_STATS_EN
                    window_count <= window_count + 32'd1;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frequency_analyzer_sequencer.sv
// tb_frequency_analyzer_sequencer: directed windows with a result scoreboard popped on each handshake.
module tb_frequency_analyzer_sequencer;
    logic clock = 1'b0;
    logic clear = 1'b0;
    logic run = 1'b0;
    logic [31:0] window_ticks = '0;
    logic [31:0] an_f0_value = '0;
    logic [31:0] an_f1_value = '0;
    logic [31:0] an_unknown = '0;
    logic an_enable;
    logic an_clear;
    logic overrun;
    logic busy;
`ifdef FREQUENCY_ANALYZER_SEQUENCER_STATS_EN
    logic [31:0] window_count;
    logic [15:0] dropped_count;
`endif
    int errors = 0;
    int checks = 0;
    typedef struct {
        logic sym;
        logic und;
        logic [31:0] f0;
        logic [31:0] f1;
        logic [31:0] unk;
    } exp_t;
    exp_t sb[$];
    frequency_analyzer_sequencer_if rif();
    frequency_analyzer_sequencer #(.MIN_DOMINANT_TICKS(32'd10)) dut (
        .clock(clock),
        .clear(clear),
        .run(run),
        .window_ticks(window_ticks),
        .an_f0_value(an_f0_value),
        .an_f1_value(an_f1_value),
        .an_unknown(an_unknown),
        .an_enable(an_enable),
        .an_clear(an_clear),
        .result(rif),
        .overrun(overrun),
        .busy(busy)
`ifdef FREQUENCY_ANALYZER_SEQUENCER_STATS_EN
        ,
        .window_count(window_count),
        .dropped_count(dropped_count)
`endif
    );
    always #5 clock = ~clock;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (clear && rif.result_valid && rif.result_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got f0=%0d f1=%0d with empty scoreboard", rif.result_f0, rif.result_f1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("symbol", rif.result_symbol, e.sym);
                check("undetermined", rif.result_undetermined, e.und);
                check("result_f0", rif.result_f0, e.f0);
                check("result_f1", rif.result_f1, e.f1);
                check("result_unknown", rif.result_unknown, e.unk);
            end
        end
    end

    // Called #1 after the edge that enters S_CLEAR; returns #1 after the edge W+3 later.
    task automatic window(input int w, input int weff, input logic [31:0] f0, input logic [31:0] f1,
                          input logic [31:0] unk, input logic sym, input logic und,
                          input bit push, input bit stop, input bit pulse);
        int en;
        int lat;
        logic pv;
        exp_t e;
        en = 0;
        lat = -1;
        window_ticks = w;
        an_f0_value = f0;
        an_f1_value = f1;
        an_unknown = unk;
        if (push) begin
            e.sym = sym;
            e.und = und;
            e.f0 = f0;
            e.f1 = f1;
            e.unk = unk;
            sb.push_back(e);
        end
        pv = rif.result_valid;
        for (int n = 1; n <= weff + 3; n++) begin
            @(posedge clock);
            #1;
            en += int'(an_enable);
            if (rif.result_valid && !pv && lat < 0) lat = n;
            pv = rif.result_valid;
            if (stop && n == weff + 1) run = 1'b0;
            if (pulse && n == weff + 2) rif.result_ready = 1'b1;
            if (pulse && n == weff + 3) rif.result_ready = 1'b0;
        end
        check("enable_cycles", en, weff);
        if (push && !pulse) check("latency", lat, weff + 3);
    endtask

    task automatic start_run();
        run = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int vcount;
        rif.result_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_an_enable", an_enable, 0);
        check("rst_an_clear", an_clear, 0);
        check("rst_valid", rif.result_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_result_f0", rif.result_f0, 0);
        check("rst_symbol", rif.result_symbol, 0);
        @(negedge clock);
        clear = 1'b1;
        rif.result_ready = 1'b1;
        @(posedge clock);
        #1;
        start_run();
        check("busy_running", busy, 1);
        window(100, 100, 20, 70, 10, 1'b1, 1'b0, 1, 1, 0);
        @(posedge clock);
        #1;
        check("idle_busy", busy, 0);
        start_run();
        window(0, 5000, 30, 5, 1, 1'b0, 1'b0, 1, 1, 0);
        @(posedge clock);
        #1;
        start_run();
        window(10, 10, 40, 40, 7, 1'b0, 1'b1, 1, 0, 0);
        window(10, 10, 5, 0, 2, 1'b0, 1'b1, 1, 1, 0);
        @(posedge clock);
        #1;
        rif.result_ready = 1'b0;
        start_run();
        window(20, 20, 100, 3, 2, 1'b0, 1'b0, 1, 0, 0);
        window(20, 20, 1, 200, 0, 1'b0, 1'b0, 0, 1, 0);
        check("overrun_set", overrun, 1);
        check("held_valid", rif.result_valid, 1);
        check("held_f0", rif.result_f0, 100);
        check("held_f1", rif.result_f1, 3);
`ifdef FREQUENCY_ANALYZER_SEQUENCER_STATS_EN
        check("dropped_count", dropped_count, 1);
        check("window_count", window_count, 6);
`endif
        @(posedge clock);
        #1;
        check("overrun_cleared", overrun, 0);
        rif.result_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        rif.result_ready = 1'b0;
        start_run();
        window(10, 10, 0, 50, 0, 1'b1, 1'b0, 1, 0, 0);
        window(10, 10, 60, 0, 4, 1'b0, 1'b0, 1, 1, 1);
        check("pulse_no_overrun", overrun, 0);
        check("pulse_valid", rif.result_valid, 1);
        check("pulse_f0", rif.result_f0, 60);
        rif.result_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        start_run();
        window_ticks = 100;
        repeat (50) @(posedge clock);
        #1;
        run = 1'b0;
        @(posedge clock);
        #1;
        check("abort_enable", an_enable, 0);
        check("abort_busy", busy, 0);
        vcount = 0;
        repeat (110) begin
            @(posedge clock);
            #1;
            vcount += int'(rif.result_valid);
        end
        check("abort_no_result", vcount, 0);
        start_run();
        repeat (30) @(posedge clock);
        #1;
        check("measure_enable", an_enable, 1);
        #2;
        clear = 1'b0;
        #1;
        check("async_an_enable", an_enable, 0);
        check("async_an_clear", an_clear, 0);
        check("async_busy", busy, 0);
        check("async_result_f0", rif.result_f0, 0);
        run = 1'b0;
        @(negedge clock);
        clear = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/frequency_analyzer_sequencer.md
Name: frequency_analyzer_sequencer

Overview:
Drives one frequency_analyzer instance through repeated fixed-length measurement windows. For each window it clears the analyzer, enables it for exactly N clocks, flushes it, captures f0/f1/unknown and decides the dominant symbol (FSK bit). Results go downstream on a valid/ready handshake. It sits between the sampled-input frontend and the symbol consumer (decoder/FIFO).

Parameters:
DEFAULT_WINDOW_TICKS, 5000, window length in clocks used when window_ticks input is 0 (100 us at 50 MHz)
MIN_DOMINANT_TICKS, 1000, minimum f0/f1 tick sum for a symbol to be valid

Ports:
clock  in  1  system clock, all logic on rising edge
clear  in  1  asynchronous active-low reset
run  in  1  level; 1 = keep running windows back to back
window_ticks  in  32  window length in clocks; 0 selects DEFAULT_WINDOW_TICKS; sampled in S_CLEAR only
an_f0_value  in  32  analyzer f0_value
an_f1_value  in  32  analyzer f1_value
an_unknown  in  32  analyzer unknown
an_enable  out  1  analyzer enable
an_clear  out  1  analyzer clear (active-low)
result_valid  out  1  result available
result_ready  in  1  downstream accepts result
result_symbol  out  1  0 = f0 dominant, 1 = f1 dominant
result_undetermined  out  1  no dominant symbol
result_f0 / result_f1 / result_unknown  out  32 each  captured analyzer totals
overrun  out  1  sticky: a window result was dropped
busy  out  1  FSM not in S_IDLE

Behaviour:
- Reset (clear=0, async): FSM S_IDLE; an_enable=0, an_clear=0 (holds analyzer cleared); result_valid=0, all result_* =0, overrun=0, busy=0; window counter 0.
- All outputs registered.
- S_IDLE: an_clear=0, an_enable=0. run=1 -> S_CLEAR. While in S_IDLE with run=0, overrun clears.
- S_CLEAR (1 cycle): an_clear=0. Latch window length W (window_ticks, or default if 0). -> S_MEASURE.
- S_MEASURE: an_clear=1, an_enable=1 for exactly W consecutive cycles (down-counter). Counter hits the last cycle -> S_FLUSH. run falling here aborts: an_enable drops next cycle, -> S_IDLE, no result produced.
- S_FLUSH (1 cycle): an_enable=0, an_clear=1. The analyzer moves its partial period into unknown. -> S_SAMPLE.
- S_SAMPLE (1 cycle): capture analyzer outputs and load them into the result register (see below). run=1 -> S_CLEAR, else S_IDLE.
- Window period back to back: W+3 cycles. result_valid rises the cycle after S_SAMPLE, i.e. W+3 cycles after S_CLEAR entry.
- Decision (unsigned 32-bit compares):
  - f1>f0 and f1>=MIN_DOMINANT_TICKS -> symbol 1, undetermined 0.
  - f0>f1 and f0>=MIN_DOMINANT_TICKS -> symbol 0, undetermined 0.
  - Otherwise, including f0==f1 -> symbol 0, undetermined 1.
- Result register (single entry): handshake completes on result_valid & result_ready. Payload is stable while valid and not ready.
  - At S_SAMPLE, if result_valid=1 and result_ready=0: new result dropped, overrun<=1, old payload kept.
  - If result_ready=1 in the same cycle: handshake completes and the new result loads, valid stays 1.
- Reset mid-window: immediate return to reset state; the pending result is lost.

Optional Feature:
FREQUENCY_ANALYZER_SEQUENCER_STATS_EN
- Defined: adds outputs window_count[31:0] (increments at each S_SAMPLE, wraps at 2^32) and dropped_count[15:0] (increments on each overrun drop, saturates at 65535). Both reset to 0.
- Undefined: ports and counters absent; everything else identical.

Decomposition:
- Package frequency_analyzer_pkg holds:
  - FSM state encoding (S_IDLE, S_CLEAR, S_MEASURE, S_FLUSH, S_SAMPLE)
  - symbol codes (SYMBOL_F0=0, SYMBOL_F1=1)
  - counter width constant (32)
- One combinational sub-module, frequency_symbol_decider: inputs f0, f1; outputs symbol, undetermined; parameter MIN_DOMINANT_TICKS.

Test Plan:
- Reset, run=1, window_ticks=100, model analyzer returning f0=20,f1=70,unknown=10, MIN_DOMINANT_TICKS=10 -> an_enable high exactly 100 cycles; result_valid at cycle 103 after S_CLEAR; symbol=1, undetermined=0, payload 20/70/10.
- window_ticks=0 -> an_enable high exactly 5000 cycles.
- f0=f1=40 -> undetermined=1. f0=5, f1=0 with MIN=10 -> undetermined=1.
- result_ready=0 over two windows -> first payload held unchanged, overrun=1 after second S_SAMPLE; run=0 returns to S_IDLE and overrun clears; with STATS_EN, dropped_count=1.
- result_ready=1 exactly in the S_SAMPLE cycle -> no overrun; new payload loaded, valid stays 1.
- run deasserted at MEASURE cycle 50 -> an_enable=0 next cycle, no result_valid. Separately, clear asserted mid-measure -> all outputs at reset values asynchronously, an_clear=0.
